fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port (din_a/wen_a) of the dual-clock fifo among NUM_REQ requesters in the clk_a write domain.
- Round-robin arbitration; each grant is a burst capped at MAX_BURST words.
- Respects the fifo full flag so no word is lost or written while full.
- Sits between requester blocks and the fifo write port; read side (clk_b) untouched.

Parameters:
- FIFO_WIDTH, 16, data word width; must match the fifo instance.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 8, max words written per grant before re-arbitration (1..255).

Ports:
- clk_a  input  1  write-domain clock (same clock as fifo clk_a).
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester "word available" (valid), level, held until accepted.
- din  input  NUM_REQ*FIFO_WIDTH  packed requester words; requester i at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- gnt  output  NUM_REQ  one-hot accept strobe; gnt[i]=1 means din slice i written this cycle.
- full  input  1  fifo full flag (clk_a domain).
- wen_a  output  1  fifo write enable.
- din_a  output  FIFO_WIDTH  fifo write data.
- owner  output  $clog2(NUM_REQ)  current/last burst owner index.
- busy  output  1  high while in GRANT state.

Behaviour:
- State regs: state {IDLE, GRANT}, owner, last (last granted index), burst_cnt (width $clog2(MAX_BURST+1)).
- Reset: state=IDLE, owner=0, last=NUM_REQ-1 (requester 0 wins first), burst_cnt=0. Consequently gnt=0, wen_a=0, busy=0; din_a=0 in IDLE.
- IDLE: if |req and !full → pick first i with req[i] searching last+1, last+2, ... (mod NUM_REQ); next cycle state=GRANT, owner=i, burst_cnt=0. If full or no req → stay IDLE. No writes in IDLE (1-cycle arbitration bubble per burst).
- GRANT, combinational outputs from registered state:
  - accept = req[owner] & !full.
  - wen_a = accept; gnt = accept ? (1<<owner) : 0; din_a = din slice[owner], and 0 when not in GRANT.
  - Zero latency: word accepted and written in the same cycle.
- GRANT transitions, evaluated each clk_a edge:
  - accept and burst_cnt+1 == MAX_BURST → IDLE, last=owner, burst_cnt=0.
  - !req[owner] → IDLE, last=owner, burst_cnt=0 (release even if full).
  - full and req[owner] → stall: stay GRANT, burst_cnt holds, no write.
  - otherwise accept → burst_cnt+1.
- Other requesters' req are ignored during GRANT; their gnt bits stay 0.
- full is sampled combinationally each cycle, so wen_a is never high while full=1.
- Wrap: round-robin index wraps NUM_REQ-1 → 0. burst_cnt never exceeds MAX_BURST-1 in state.
- Reset mid-burst: next cycle IDLE and all outputs at reset values. A word presented in the reset cycle is not written (gnt=0).
- Requester contract: din slice stable while req high. Dropping req without gnt is legal (word withdrawn).

Decomposition:
- Package fifo_arb_pkg:
  - state typedef {IDLE, GRANT};
  - localparams ID_W=$clog2(NUM_REQ), CNT_W=$clog2(MAX_BURST+1).
- Sub-module rr_picker (combinational): inputs req and last; outputs found and idx of next requester after last.
- fifo_wr_arbiter holds the FSM, counter and output muxing.

Test Plan:
- Single requester: req[0] held for 20 words, full=0, MAX_BURST=8 → wen_a bursts of 8, 8, 4 with one idle cycle between; din_a matches din slice 0 in order; gnt=4'b0001 on each write.
- All four req high, each with distinct data → burst owner order 0,1,2,3,0; each burst 8 writes; gnt one-hot and never two bits set.
- Mid-burst full: owner 1 after 3 writes, full=1 for 5 cycles → wen_a=0 and gnt=0 for those 5 cycles, burst_cnt holds at 3; then 5 more writes, then release to requester 2.
- Req withdrawal: owner 2 drops req after 2 writes → IDLE next cycle, last=2; requester 3 granted next if requesting, else wrap to 0.
- Full at arbitration: full=1 with req=4'b1111 → stays IDLE, busy=0, no gnt. Full falls → requester (last+1) granted next cycle.
- Reset mid-burst: rst=1 on the 4th write cycle of owner 0 → following cycle wen_a=0, busy=0, owner=0. After release, requester 0 is granted first again.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the fifo write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int NUM_REQ_DEF    = 4;
    localparam int MAX_BURST_DEF  = 8;

    localparam int ID_W  = $clog2(NUM_REQ_DEF);
    localparam int CNT_W = $clog2(MAX_BURST_DEF + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - round-robin search for the next requester after last
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest position back to last+1 so the nearest requester wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the fifo write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                          clk_a,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          full,
    output logic                          wen_a,
    output logic [FIFO_WIDTH-1:0]         din_a,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              accept;
    logic              burst_done;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A word is taken only when the owner offers one and the fifo has room;
    // the reset cycle never writes so a word in flight is not lost half-way.
    assign accept     = (state_q == GRANT) && req[owner_q] && !full && !rst;
    assign burst_done = (int'(cnt_q) + 1 == MAX_BURST);

    // Write-port and status outputs, combinational from registered state.
    always_comb begin
        wen_a        = accept;
        gnt          = '0;
        gnt[owner_q] = accept;
        din_a        = '0;
        if (state_q == GRANT) begin
            din_a = din[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH];
        end
        busy  = (state_q == GRANT);
        owner = owner_q;
    end

    // Next-state: arbitrate in IDLE, count/stall/release in GRANT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found && !full) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (accept && burst_done) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (!req[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + BCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; last starts at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic            clk_a = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [63:0]     din;
    logic [3:0]      gnt;
    logic            full;
    logic            wen_a;
    logic [15:0]     din_a;
    logic [ID_W-1:0] owner;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int seq [4];

    fifo_wr_arbiter #(
        .FIFO_WIDTH (16),
        .NUM_REQ    (4),
        .MAX_BURST  (8)
    ) dut (
        .clk_a (clk_a),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .full  (full),
        .wen_a (wen_a),
        .din_a (din_a),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk_a = ~clk_a;

    // Requester i presents word {i, seq[i]}; seq advances once a word is accepted.
    always_comb begin
        din = '0;
        for (int i = 0; i < 4; i++) begin
            din[i*16 +: 16] = {4'(i), 12'(seq[i])};
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s actual=%0h required=%0h", tag, obs, expv);
        end
    endtask

    // Check one cycle's outputs, advance the requester model, move past the next edge.
    task automatic cyc(input logic w, input logic [3:0] g, input int own, input logic b,
                       input string tag);
        logic [15:0] exp_data;
        #1;
        chk(32'(wen_a), 32'(w), {tag, " wen_a"});
        chk(32'(gnt), 32'(g), {tag, " gnt"});
        chk(32'(owner), 32'(own), {tag, " owner"});
        chk(32'(busy), 32'(b), {tag, " busy"});
        if (w) begin
            exp_data = {4'(own), 12'(seq[own])};
            chk(32'(din_a), 32'(exp_data), {tag, " din_a"});
            seq[own] = seq[own] + 1;
        end else if (!b) begin
            chk(32'(din_a), 32'h0, {tag, " din_a idle"});
        end
        @(posedge clk_a);
        #1;
    endtask

    int bursts [3]  = '{8, 8, 4};
    int owners [5]  = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < 4; i++) seq[i] = i * 256;
        rst  = 1'b1;
        req  = 4'b0000;
        full = 1'b0;
        @(posedge clk_a);
        #1;
        @(posedge clk_a);
        #1;
        rst = 1'b0;
        cyc(1'b0, 4'b0000, 0, 1'b0, "reset");

        // Single requester, 20 words: bursts of 8, 8, 4.
        req = 4'b0001;
        for (int bi = 0; bi < 3; bi++) begin
            cyc(1'b0, 4'b0000, 0, 1'b0, "t1 bubble");
            for (int k = 0; k < bursts[bi]; k++) cyc(1'b1, 4'b0001, 0, 1'b1, "t1 write");
        end
        req = 4'b0000;
        cyc(1'b0, 4'b0000, 0, 1'b1, "t1 release");
        cyc(1'b0, 4'b0000, 0, 1'b0, "t1 idle");

        // All requesters: owner order 0,1,2,3,0 after a fresh reset.
        rst = 1'b1;
        cyc(1'b0, 4'b0000, 0, 1'b0, "t2 rst");
        rst = 1'b0;
        req = 4'b1111;
        begin
            int prev;
            prev = 0;
            for (int bi = 0; bi < 5; bi++) begin
                cyc(1'b0, 4'b0000, prev, 1'b0, "t2 bubble");
                for (int k = 0; k < 8; k++)
                    cyc(1'b1, 4'(1 << owners[bi]), owners[bi], 1'b1, "t2 write");
                prev = owners[bi];
            end
        end

        // Mid-burst full on owner 1: 3 writes, 5 stalls, 5 writes, release.
        cyc(1'b0, 4'b0000, 0, 1'b0, "t3 bubble");
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0010, 1, 1'b1, "t3 write a");
        full = 1'b1;
        for (int k = 0; k < 5; k++) cyc(1'b0, 4'b0000, 1, 1'b1, "t3 stall");
        full = 1'b0;
        for (int k = 0; k < 5; k++) cyc(1'b1, 4'b0010, 1, 1'b1, "t3 write b");
        cyc(1'b0, 4'b0000, 1, 1'b0, "t3 release");

        // Withdrawal by owner 2 after 2 words, requester 3 next.
        for (int k = 0; k < 2; k++) cyc(1'b1, 4'b0100, 2, 1'b1, "t4 write");
        req = 4'b1011;
        cyc(1'b0, 4'b0000, 2, 1'b1, "t4 drop");
        cyc(1'b0, 4'b0000, 2, 1'b0, "t4 bubble");
        cyc(1'b1, 4'b1000, 3, 1'b1, "t4 next");
        req = 4'b0000;
        cyc(1'b0, 4'b0000, 3, 1'b1, "t4 release");

        // Full at arbitration holds IDLE; release wraps to requester 0.
        req  = 4'b1111;
        full = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, 4'b0000, 3, 1'b0, "t5 full idle");
        full = 1'b0;
        cyc(1'b0, 4'b0000, 3, 1'b0, "t5 bubble");
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0001, 0, 1'b1, "t5 write");

        // Reset on the 4th write cycle: nothing written, back to reset state.
        rst = 1'b1;
        cyc(1'b0, 4'b0000, 0, 1'b1, "t6 rst cycle");
        rst = 1'b0;
        cyc(1'b0, 4'b0000, 0, 1'b0, "t6 after rst");
        cyc(1'b1, 4'b0001, 0, 1'b1, "t6 regrant");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
